// File: rtl/jtag_uart_port_arbiter.sv
// Shares the JTAG-UART Avalon slave between continuous RX polling and a
// FIFO-buffered TX path, with a cached write-space count to limit control reads.
//
// state        | meaning
// ST_IDLE      | no request; arbitrate RX vs TX for the next transaction
// ST_RX_READ   | read data register (addr 0), capture byte when RVALID
// ST_CTRL_READ | read control register (addr 1) to refresh cached WSPACE
// ST_TX_WRITE  | write FIFO head to data register, pop on completion
module jtag_uart_port_arbiter #(
  parameter int TX_FIFO_AW = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_VALID,
  input  logic [7:0]  iTX_DATA,
  input  logic        iTX_WRREQ,
  output logic        oTX_FULL,
  output logic        oTX_OVERFLOW
);

  localparam int DEPTH = 1 << TX_FIFO_AW;
  localparam logic GRANT_RX = 1'b0;
  localparam logic GRANT_TX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_READ,
    ST_CTRL_READ,
    ST_TX_WRITE
  } state_t;

  state_t state, stateNext;
  logic                  lastGrant;
  logic [15:0]           wspace;
  logic [7:0]            txMem [DEPTH];
  logic [TX_FIFO_AW-1:0] wrPtr, rdPtr;
  logic [TX_FIFO_AW:0]   txCount;
  logic                  txPush, txPop, txReq, busDone;
  logic                  unusedRdBits;

  assign unusedRdBits = ^iJTAG_SLAVE_RDDATA[14:8];
  assign busDone = !iJTAG_SLAVE_WAIT;
  assign txReq   = (txCount != '0);
  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign oTX_FULL = txCount[TX_FIFO_AW];
  assign txPush   = iTX_WRREQ && !oTX_FULL;
  assign txPop    = (state == ST_TX_WRITE) && busDone;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext          = state;
    oJTAG_SLAVE_ADDR   = 1'b0;
    oJTAG_SLAVE_RDREQ  = 1'b0;
    oJTAG_SLAVE_WRREQ  = 1'b0;
    oJTAG_SLAVE_WRDATA = '0;
    case (state)
      ST_IDLE: begin
        if (txReq && lastGrant == GRANT_RX)
          stateNext = (wspace != '0) ? ST_TX_WRITE : ST_CTRL_READ;
        else
          stateNext = ST_RX_READ;
      end
      ST_RX_READ: begin
        oJTAG_SLAVE_RDREQ = 1'b1;
        if (busDone) stateNext = ST_IDLE;
      end
      ST_CTRL_READ: begin
        oJTAG_SLAVE_ADDR  = 1'b1;
        oJTAG_SLAVE_RDREQ = 1'b1;
        // Zero space yields the bus back to RX so a full host buffer cannot starve it.
        if (busDone)
          stateNext = (iJTAG_SLAVE_RDDATA[31:16] == '0) ? ST_IDLE : ST_TX_WRITE;
      end
      ST_TX_WRITE: begin
        oJTAG_SLAVE_WRREQ  = 1'b1;
        oJTAG_SLAVE_WRDATA = {24'd0, txMem[rdPtr]};
        if (busDone) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lastGrant <= GRANT_RX;
      wspace    <= '0;
      oRX_DATA  <= '0;
      oRX_VALID <= 1'b0;
    end else begin
      oRX_VALID <= 1'b0;
      if (busDone) begin
        case (state)
          ST_RX_READ: begin
            oRX_DATA  <= iJTAG_SLAVE_RDDATA[7:0];
            oRX_VALID <= iJTAG_SLAVE_RDDATA[15];
            lastGrant <= GRANT_RX;
          end
          ST_CTRL_READ: begin
            wspace <= iJTAG_SLAVE_RDDATA[31:16];
            if (iJTAG_SLAVE_RDDATA[31:16] == '0) lastGrant <= GRANT_TX;
          end
          ST_TX_WRITE: begin
            wspace    <= wspace - 16'd1;
            lastGrant <= GRANT_TX;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (txPush) txMem[wrPtr] <= iTX_DATA;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      txCount      <= '0;
      oTX_OVERFLOW <= 1'b0;
    end else begin
      if (txPush) wrPtr <= wrPtr + 1'b1;
      if (txPop)  rdPtr <= rdPtr + 1'b1;
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: ;
      endcase
      if (iTX_WRREQ && oTX_FULL) oTX_OVERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_uart_port_arbiter.sv
// Directed bench for jtag_uart_port_arbiter: a small Avalon slave model
// answers reads and logs each completed transaction for comparison.
module tb_jtag_uart_port_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        addr, rdReq, wrReq, waitSig;
  logic [31:0] rdData, wrData;
  logic [7:0]  rxData, txData;
  logic        rxValid, txWrReq, txFull, txOvf;

  jtag_uart_port_arbiter #(.TX_FIFO_AW(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oJTAG_SLAVE_ADDR(addr), .oJTAG_SLAVE_RDREQ(rdReq),
    .iJTAG_SLAVE_RDDATA(rdData), .oJTAG_SLAVE_WRREQ(wrReq),
    .oJTAG_SLAVE_WRDATA(wrData), .iJTAG_SLAVE_WAIT(waitSig),
    .oRX_DATA(rxData), .oRX_VALID(rxValid),
    .iTX_DATA(txData), .iTX_WRREQ(txWrReq),
    .oTX_FULL(txFull), .oTX_OVERFLOW(txOvf)
  );

  always #5 iCLK = ~iCLK;

  int total = 0, bad = 0;
  logic [31:0] rxWord;
  logic [15:0] wsSeq [4];
  int wsIdx;
  int rxReads, ctrlReads, writes, wrReqCycles, stableErr, rxValids, backToBack, logN;
  logic [7:0]  lastRx, lastWr;
  logic [7:0]  wrHist [4];
  logic [31:0] logCode, prevWrData;
  logic        prevWrReq, prevValid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  task automatic clearMon();
    rxReads = 0; ctrlReads = 0; writes = 0; wrReqCycles = 0; stableErr = 0;
    rxValids = 0; backToBack = 0; logN = 0; logCode = '0;
  endtask

  task automatic logPush(input logic [1:0] code);
    if (logN < 16) begin
      logCode = {logCode[29:0], code};
      logN++;
    end
  endtask

  task automatic alignRx();
    for (int i = 0; i < 20 && !(rdReq && !addr); i++) cyc(1);
    check("alignRx", {31'd0, rdReq && !addr}, 32'd1);
  endtask

  task automatic alignWr();
    for (int i = 0; i < 20 && !wrReq; i++) cyc(1);
    check("alignWr", {31'd0, wrReq}, 32'd1);
  endtask

  // Slave model: response for the current cycle is set mid-cycle, before the DUT samples it.
  always @(negedge iCLK) begin
    if (rdReq && addr) begin
      rdData = {wsSeq[wsIdx], 16'h0000};
      if (!waitSig) begin
        ctrlReads++;
        logPush(2'd2);
        if (wsIdx < 3) wsIdx++;
      end
    end else begin
      rdData = rxWord;
    end
    if (rdReq && !addr && !waitSig) begin
      rxReads++;
      logPush(2'd1);
    end
    if (wrReq) begin
      wrReqCycles++;
      if (prevWrReq && (wrData !== prevWrData || addr !== 1'b0)) stableErr++;
      if (!waitSig) begin
        if (writes < 4) wrHist[writes] = wrData[7:0];
        writes++;
        lastWr = wrData[7:0];
        logPush(2'd3);
      end
    end
    if (rxValid) begin
      rxValids++;
      lastRx = rxData;
      if (prevValid) backToBack++;
    end
    prevWrReq  = wrReq;
    prevWrData = wrData;
    prevValid  = rxValid;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    iRST = 1'b1; waitSig = 1'b0; txData = '0; txWrReq = 1'b0;
    rxWord = 32'h0000_8041; rdData = '0; wsIdx = 0;
    wsSeq[0] = 16'h0; wsSeq[1] = 16'h0; wsSeq[2] = 16'h0; wsSeq[3] = 16'h0;
    prevWrReq = 1'b0; prevWrData = '0; prevValid = 1'b0; lastRx = '0; lastWr = '0;
    for (int i = 0; i < 4; i++) wrHist[i] = '0;
    clearMon();

    // reset state
    cyc(2);
    check("rstRdReq", {31'd0, rdReq}, 32'd0);
    check("rstWrReq", {31'd0, wrReq}, 32'd0);
    check("rstAddr", {31'd0, addr}, 32'd0);
    check("rstWrData", wrData, 32'd0);
    check("rstRxValid", {31'd0, rxValid}, 32'd0);
    check("rstRxData", {24'd0, rxData}, 32'd0);
    check("rstFull", {31'd0, txFull}, 32'd0);
    check("rstOvf", {31'd0, txOvf}, 32'd0);
    check("rstWspace", {16'd0, dut.wspace}, 32'd0);
    iRST = 1'b0;

    // RX only
    cyc(4);
    clearMon();
    cyc(20);
    check("rxOnlyReads", rxReads, 10);
    check("rxOnlyValids", rxValids, 10);
    check("rxOnlyB2B", backToBack, 0);
    check("rxOnlyData", {24'd0, lastRx}, 32'h41);
    check("rxOnlyNoWr", wrReqCycles, 0);

    // RVALID=0
    rxWord = 32'h0000_0041;
    cyc(3);
    clearMon();
    cyc(20);
    check("noValidPulses", rxValids, 0);
    check("noValidReads", rxReads, 10);
    rxWord = 32'h0000_8041;

    // TX with space: R C W R W then RX only
    wsIdx = 0; wsSeq[0] = 16'h0040;
    alignRx();
    clearMon();
    txData = 8'h55; txWrReq = 1'b1;
    cyc(1);
    txData = 8'hAA;
    cyc(1);
    txWrReq = 1'b0;
    cyc(40);
    check("spaceLog", logCode, 32'h6DD5_5555);
    check("spaceWrites", writes, 2);
    check("spaceWr0", {24'd0, wrHist[0]}, 32'h55);
    check("spaceWr1", {24'd0, wrHist[1]}, 32'hAA);
    check("spaceCtrl", ctrlReads, 1);
    check("spaceWspace", {16'd0, dut.wspace}, 32'h3E);

    // TX no space: three zero control reads, each followed by RX, then one write
    iRST = 1'b1; cyc(2); iRST = 1'b0;
    wsIdx = 0; wsSeq[0] = 16'h0; wsSeq[1] = 16'h0; wsSeq[2] = 16'h0; wsSeq[3] = 16'h1;
    alignRx();
    clearMon();
    txData = 8'h33; txWrReq = 1'b1;
    cyc(1);
    txWrReq = 1'b0;
    cyc(50);
    check("noSpaceLog", logCode, 32'h6666_D555);
    check("noSpaceCtrl", ctrlReads, 4);
    check("noSpaceWrites", writes, 1);
    check("noSpaceData", {24'd0, lastWr}, 32'h33);

    // WAIT stretching on a write
    wsIdx = 0; wsSeq[0] = 16'h0010;
    alignRx();
    clearMon();
    txData = 8'h77; txWrReq = 1'b1;
    cyc(1);
    txWrReq = 1'b0;
    cyc(2);
    check("stretchStart", {31'd0, wrReq}, 32'd1);
    waitSig = 1'b1;
    cyc(5);
    waitSig = 1'b0;
    cyc(10);
    check("stretchCycles", wrReqCycles, 6);
    check("stretchStable", stableErr, 0);
    check("stretchWrites", writes, 1);
    check("stretchData", {24'd0, lastWr}, 32'h77);
    check("stretchPops", {27'd0, dut.txCount}, 32'd0);

    // overflow with stalled slave
    alignRx();
    waitSig = 1'b1;
    for (int i = 0; i < 17; i++) begin
      txData = 8'hA0 + 8'(i); txWrReq = 1'b1;
      cyc(1);
      if (i == 15) begin
        check("fullAt16", {31'd0, txFull}, 32'd1);
        check("noOvfAt16", {31'd0, txOvf}, 32'd0);
      end
    end
    txWrReq = 1'b0;
    check("ovfSet", {31'd0, txOvf}, 32'd1);
    check("fullStill", {31'd0, txFull}, 32'd1);

    // reset in the middle of a stalled write
    waitSig = 1'b0;
    alignWr();
    waitSig = 1'b1;
    check("midWrData", wrData, 32'h0000_00A0);
    #3 iRST = 1'b1;
    #1;
    check("rstMidWrReq", {31'd0, wrReq}, 32'd0);
    check("rstMidRdReq", {31'd0, rdReq}, 32'd0);
    check("rstMidAddr", {31'd0, addr}, 32'd0);
    check("rstMidWrData", wrData, 32'd0);
    check("rstMidFull", {31'd0, txFull}, 32'd0);
    check("rstMidOvf", {31'd0, txOvf}, 32'd0);
    check("rstMidValid", {31'd0, rxValid}, 32'd0);
    cyc(1);
    iRST = 1'b0; waitSig = 1'b0;
    clearMon();
    cyc(20);
    check("postRstWrites", wrReqCycles, 0);
    check("postRstCtrl", ctrlReads, 0);
    check("postRstReads", rxReads, 10);
    check("postRstCount", {27'd0, dut.txCount}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
